// File: rtl/pipeline_config_sequencer_pkg.sv
// rtl/pipeline_config_sequencer_pkg.sv - opcodes, error codes, states and field widths for the config sequencer
package pipeline_config_sequencer_pkg;

   localparam int BLOCK_INSTR_WIDTH    = 24;
   localparam int BLOCK_REG_ADDR_WIDTH = 4;
   localparam int RST_SETTLE_CYCLES    = 2;

   typedef enum logic [2:0] {
      OP_NOP         = 3'd0,
      OP_INSTR_WRITE = 3'd1,
      OP_REG_WRITE   = 3'd2,
      OP_COMMIT      = 3'd3,
      OP_ALLOC_DELAY = 3'd4,
      OP_FULL_RESET  = 3'd5,
      OP_CLEAR_ERR   = 3'd6,
      OP_ILLEGAL     = 3'd7
   } cfg_op_e;

   typedef enum logic [1:0] {
      CFG_ERR_NONE    = 2'd0,
      CFG_ERR_TIMEOUT = 2'd1,
      CFG_ERR_ILLEGAL = 2'd2
   } cfg_err_e;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_ISSUE       = 3'd1,
      S_WAIT_ACK    = 3'd2,
      S_WAIT_SAMPLE = 3'd3,
      S_WAIT_RST    = 3'd4
   } cfg_state_e;

endpackage

// File: rtl/pipeline_config_sequencer_ack_timer.sv
// rtl/pipeline_config_sequencer_ack_timer.sv - loadable down-counter that flags expiry on reaching zero
module pipeline_config_sequencer_ack_timer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_load,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_start) begin
         r_count <= i_load;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/pipeline_config_sequencer.sv
// rtl/pipeline_config_sequencer.sv - serialises host config commands into dsp_pipeline strobe/ack handshakes
module pipeline_config_sequencer
   import pipeline_config_sequencer_pkg::*;
#(
   parameter int data_width  = 16,
   parameter int n_blocks    = 256,
   parameter int cmd_width   = 32,
   parameter int ack_timeout = 255
) (
   input  logic                                            i_clk,
   input  logic                                            i_reset,
   input  logic                                            i_cmd_valid,
   output logic                                            o_cmd_ready,
   input  logic [2:0]                                      i_cmd_op,
   input  logic [$clog2(n_blocks)-1:0]                     i_cmd_block,
   input  logic [BLOCK_REG_ADDR_WIDTH-1:0]                 i_cmd_reg,
   input  logic [cmd_width-1:0]                            i_cmd_data,
   output logic [$clog2(n_blocks)-1:0]                     o_block_target,
   output logic [$clog2(n_blocks)+BLOCK_REG_ADDR_WIDTH-1:0] o_reg_target,
   output logic [BLOCK_INSTR_WIDTH-1:0]                    o_instr_val,
   output logic [data_width-1:0]                           o_ctrl_data,
   output logic [2*data_width-1:0]                         o_buf_init_delay,
   output logic                                            o_instr_write,
   output logic                                            o_reg_write,
   output logic                                            o_reg_writes_commit,
   output logic                                            o_alloc_delay,
   output logic                                            o_full_reset,
   input  logic                                            i_pipe_ready,
   input  logic                                            i_reg_write_ack,
   input  logic                                            i_instr_write_ack,
   input  logic                                            i_resetting,
   output logic                                            o_busy,
   output logic                                            o_err,
   output logic [1:0]                                      o_err_code,
   output logic [15:0]                                     o_done_count
);

   localparam int BA = $clog2(n_blocks);
   localparam int TW = $clog2(ack_timeout + 1);
   // Timer reaches zero in the last cycle of the ack window (ISSUE plus ack_timeout-1 cycles).
   localparam logic [TW-1:0] ACK_LOAD = TW'(ack_timeout - 2);
   localparam logic [TW-1:0] RST_LOAD = TW'(RST_SETTLE_CYCLES);

   cfg_state_e                     r_state, w_next;
   cfg_op_e                        r_op;
   logic [BA-1:0]                  r_block;
   logic [BLOCK_REG_ADDR_WIDTH-1:0] r_reg;
   logic [cmd_width-1:0]           r_data;
   logic                           r_err;
   cfg_err_e                       r_err_code;
   logic [15:0]                    r_done_count;

   logic          w_accept, w_ack, w_expired;
   logic          w_complete, w_timeout, w_illegal, w_clear;
   logic          w_timer_start;
   logic [TW-1:0] w_timer_load;

   pipeline_config_sequencer_ack_timer #(.WIDTH(TW)) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (w_timer_start),
      .i_load    (w_timer_load),
      .o_expired (w_expired)
   );

   assign w_accept = i_cmd_valid && (r_state == S_IDLE);
   assign w_ack    = (r_op == OP_INSTR_WRITE) ? i_instr_write_ack : i_reg_write_ack;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next              = r_state;
      o_instr_write       = 1'b0;
      o_reg_write         = 1'b0;
      o_reg_writes_commit = 1'b0;
      o_alloc_delay       = 1'b0;
      o_full_reset        = 1'b0;
      w_complete          = 1'b0;
      w_timeout           = 1'b0;
      w_illegal           = 1'b0;
      w_clear             = 1'b0;
      w_timer_start       = 1'b0;
      w_timer_load        = ACK_LOAD;
      case (r_state)
         S_IDLE: if (i_cmd_valid) w_next = S_ISSUE;
         S_ISSUE: begin
            case (r_op)
               OP_INSTR_WRITE, OP_REG_WRITE: begin
                  o_instr_write = (r_op == OP_INSTR_WRITE);
                  o_reg_write   = (r_op == OP_REG_WRITE);
                  if (w_ack) begin
                     w_next     = S_IDLE;
                     w_complete = 1'b1;
                  end else begin
                     w_next        = S_WAIT_ACK;
                     w_timer_start = 1'b1;
                  end
               end
               OP_COMMIT: w_next = S_WAIT_SAMPLE;
               OP_FULL_RESET: begin
                  o_full_reset  = 1'b1;
                  w_next        = S_WAIT_RST;
                  w_timer_start = 1'b1;
                  w_timer_load  = RST_LOAD;
               end
               OP_ILLEGAL: begin
                  w_illegal = 1'b1;
                  w_next    = S_IDLE;
               end
               default: begin
                  o_alloc_delay = (r_op == OP_ALLOC_DELAY);
                  w_clear       = (r_op == OP_CLEAR_ERR);
                  w_complete    = 1'b1;
                  w_next        = S_IDLE;
               end
            endcase
         end
         S_WAIT_ACK: begin
            // An ack in the expiry cycle still wins over the timeout.
            if (w_ack) begin
               w_complete = 1'b1;
               w_next     = S_IDLE;
            end else if (w_expired) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_WAIT_SAMPLE: begin
            if (i_pipe_ready) begin
               o_reg_writes_commit = 1'b1;
               w_complete          = 1'b1;
               w_next              = S_IDLE;
            end
         end
         S_WAIT_RST: begin
            if (w_expired && !i_resetting) begin
               w_complete = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_op         <= OP_NOP;
         r_block      <= '0;
         r_reg        <= '0;
         r_data       <= '0;
         r_err        <= 1'b0;
         r_err_code   <= CFG_ERR_NONE;
         r_done_count <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= cfg_op_e'(i_cmd_op);
            r_block <= i_cmd_block;
            r_reg   <= i_cmd_reg;
            r_data  <= i_cmd_data;
         end
         if (w_complete) r_done_count <= r_done_count + 16'd1;
         if (w_clear) begin
            r_err      <= 1'b0;
            r_err_code <= CFG_ERR_NONE;
         end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_err_code <= CFG_ERR_TIMEOUT;
         end else if (w_illegal) begin
            r_err      <= 1'b1;
            r_err_code <= CFG_ERR_ILLEGAL;
         end
      end
   end

   assign o_cmd_ready      = (r_state == S_IDLE);
   assign o_busy           = (r_state != S_IDLE);
   assign o_err            = r_err;
   assign o_err_code       = r_err_code;
   assign o_done_count     = r_done_count;
   assign o_block_target   = r_block;
   assign o_reg_target     = {r_block, r_reg};
   assign o_instr_val      = r_data[BLOCK_INSTR_WIDTH-1:0];
   assign o_ctrl_data      = r_data[data_width-1:0];
   assign o_buf_init_delay = r_data[2*data_width-1:0];

endmodule
